pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller_pkg.sv | 29 ++
 rtl/pipeline_hazard_controller_flush_arbiter.sv | 25 ++
 rtl/pipeline_hazard_controller.sv | 172 +++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: basic address/counter types,
// the control FSM states and the oldest-requester flush priority function.
package pipeline_hazard_controller_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [63:0] cnt64_t;
   typedef logic [31:0] cnt32_t;

   localparam int MAX_STAGES  = 32;
   localparam int STAGE_IDX_W = 5;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } hz_state_e;

   // Highest set bit wins: the oldest stage owns the redirect.
   function automatic logic [STAGE_IDX_W-1:0] flush_winner(input logic [MAX_STAGES-1:0] req);
      logic [STAGE_IDX_W-1:0] idx;
      idx = {STAGE_IDX_W{1'b0}};
      for (int i = 0; i < MAX_STAGES; i++) begin
         idx = req[i] ? STAGE_IDX_W'(i) : idx;
      end
      return idx;
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_flush_arbiter.sv
// Flush arbiter: picks the oldest flush requester and muxes out its redirect PC.
module flush_arbiter
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int ADDR_WIDTH = 32
) (
   input  logic [NUM_STAGES-1:0]                 i_req,
   input  logic [NUM_STAGES-1:0][ADDR_WIDTH-1:0] i_pc,
   output logic                                  o_valid,
   output logic [STAGE_IDX_W-1:0]                o_idx,
   output logic [ADDR_WIDTH-1:0]                 o_pc
);

   // Priority encode the requests and select the winner's PC.
   always_comb begin
      o_valid = |i_req;
      o_idx   = flush_winner(MAX_STAGES'(i_req));
      o_pc    = {ADDR_WIDTH{1'b0}};
      for (int i = 0; i < NUM_STAGES; i++) begin
         o_pc = (o_idx == STAGE_IDX_W'(i)) ? i_pc[i] : o_pc;
      end
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: stall back-pressure, oldest-wins flush/redirect,
// drain-and-halt sequencing, plus commit and stall-cycle counters.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int NUM_STAGES   = 5,
   parameter int ADDR_WIDTH   = 32,
   parameter int COMMIT_WIDTH = 2,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                                  clk,
   input  logic                                  rstN,
   input  logic [NUM_STAGES-1:0]                 stallReq,
   input  logic [NUM_STAGES-1:0]                 stageValid,
   input  logic [NUM_STAGES-1:0]                 flushReq,
   input  logic [NUM_STAGES-1:0][ADDR_WIDTH-1:0] flushPc,
   input  logic [$clog2(COMMIT_WIDTH+1)-1:0]     commitCount,
   input  logic                                  haltReq,
   input  logic                                  resumeReq,
   output logic [NUM_STAGES-1:0]                 stall,
   output logic [NUM_STAGES-1:0]                 bubble,
   output logic [NUM_STAGES-1:0]                 flush,
   output logic [ADDR_WIDTH-1:0]                 nextPc,
   output logic                                  nextPcValid,
   output logic                                  halted,
   output logic [63:0]                           opCommitCount,
   output logic [31:0]                           stallCycleCount
);

   localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

   hz_state_e              r_state;
   logic [NUM_STAGES-1:0]  r_flush;
   logic [STAGE_IDX_W-1:0] r_flush_idx;
   logic [3:0]             r_flush_cnt;
   logic [ADDR_WIDTH-1:0]  r_next_pc;
   logic                   r_next_pc_valid;
   logic                   r_halted;
   cnt64_t                 r_op_commit_count;
   cnt32_t                 r_stall_cycle_count;

   logic                   w_fl_valid;
   logic [STAGE_IDX_W-1:0] w_fl_idx;
   logic [ADDR_WIDTH-1:0]  w_fl_pc;
   logic [NUM_STAGES-1:0]  w_fl_mask;
   logic                   w_accept;
   logic                   w_acc;
   logic [NUM_STAGES-1:0]  w_stall_pre;
   logic [NUM_STAGES-1:0]  w_bubble_pre;
   logic [NUM_STAGES-1:0]  w_stall;
   logic [NUM_STAGES-1:0]  w_bubble;
   logic                   w_unused;

   assign w_unused = stageValid[0];

   flush_arbiter #(
      .NUM_STAGES (NUM_STAGES),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_flush_arbiter (
      .i_req   (flushReq),
      .i_pc    (flushPc),
      .o_valid (w_fl_valid),
      .o_idx   (w_fl_idx),
      .o_pc    (w_fl_pc)
   );

   // Kill mask: every stage younger than the winning requester.
   always_comb begin
      for (int i = 0; i < NUM_STAGES; i++) begin
         w_fl_mask[i] = (STAGE_IDX_W'(i) < w_fl_idx);
      end
   end

   // Flush acceptance; during FLUSH only an older requester may preempt.
   always_comb begin
      case (r_state)
         ST_RUN, ST_DRAIN: w_accept = w_fl_valid;
         ST_FLUSH:         w_accept = w_fl_valid && (w_fl_idx > r_flush_idx);
         ST_HALTED:        w_accept = 1'b0;
         default:          w_accept = 1'b0;
      endcase
   end

   // Stall back-pressure toward younger stages, bubbles at the stall boundary.
   always_comb begin
      w_acc       = 1'b0;
      w_stall_pre = {NUM_STAGES{1'b0}};
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         w_acc          = w_acc | stallReq[i];
         w_stall_pre[i] = w_acc;
      end
      w_stall_pre[0]  = w_stall_pre[0] | (r_state == ST_DRAIN) | (r_state == ST_HALTED);
      w_bubble_pre    = {NUM_STAGES{1'b0}};
      for (int i = 1; i < NUM_STAGES; i++) begin
         w_bubble_pre[i] = w_stall_pre[i-1] & ~w_stall_pre[i];
      end
      w_stall  = w_stall_pre & ~r_flush;
      w_bubble = w_bubble_pre & ~r_flush;
   end

   // Control FSM, redirect registers and counters.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_state             <= ST_RUN;
         r_flush             <= {NUM_STAGES{1'b0}};
         r_flush_idx         <= {STAGE_IDX_W{1'b0}};
         r_flush_cnt         <= 4'd0;
         r_next_pc           <= {ADDR_WIDTH{1'b0}};
         r_next_pc_valid     <= 1'b0;
         r_halted            <= 1'b0;
         r_op_commit_count   <= 64'd0;
         r_stall_cycle_count <= 32'd0;
      end else begin
         r_op_commit_count <= r_op_commit_count + 64'(commitCount);
         if (w_stall[0] && (r_state != ST_HALTED) && (r_stall_cycle_count != 32'hFFFF_FFFF)) begin
            r_stall_cycle_count <= r_stall_cycle_count + 32'd1;
         end
         r_next_pc_valid <= 1'b0;
         if (w_accept) begin
            r_state         <= ST_FLUSH;
            r_flush         <= w_fl_mask;
            r_flush_idx     <= w_fl_idx;
            r_flush_cnt     <= FLUSH_RELOAD;
            r_next_pc       <= w_fl_pc;
            r_next_pc_valid <= 1'b1;
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (haltReq) r_state <= ST_DRAIN;
               end
               ST_FLUSH: begin
                  if (r_flush_cnt == 4'd0) begin
                     r_flush <= {NUM_STAGES{1'b0}};
                     r_state <= haltReq ? ST_DRAIN : ST_RUN;
                  end else begin
                     r_flush_cnt <= r_flush_cnt - 4'd1;
                  end
               end
               ST_DRAIN: begin
                  if (!haltReq) begin
                     r_state <= ST_RUN;
                  end else if (stageValid[NUM_STAGES-1:1] == {(NUM_STAGES-1){1'b0}}) begin
                     r_state  <= ST_HALTED;
                     r_halted <= 1'b1;
                  end
               end
               ST_HALTED: begin
                  if (resumeReq) begin
                     r_state  <= ST_RUN;
                     r_halted <= 1'b0;
                  end
               end
               default: begin
                  r_state  <= ST_RUN;
                  r_flush  <= {NUM_STAGES{1'b0}};
                  r_halted <= 1'b0;
               end
            endcase
         end
      end
   end

   assign stall           = w_stall;
   assign bubble          = w_bubble;
   assign flush           = r_flush;
   assign nextPc          = r_next_pc;
   assign nextPcValid     = r_next_pc_valid;
   assign halted          = r_halted;
   assign opCommitCount   = r_op_commit_count;
   assign stallCycleCount = r_stall_cycle_count;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (FLUSH_CYCLES 1 and 3).
module tb_pipeline_hazard_controller;
   import pipeline_hazard_controller_pkg::*;

   logic           clk;
   logic           rstN;
   logic [4:0]     stallReq;
   logic [4:0]     stageValid;
   logic [4:0]     flushReq;
   addr_t [4:0]    flushPc;
   logic [1:0]     commitCount;
   logic           haltReq;
   logic           resumeReq;

   logic [4:0]  stall1, bubble1, flush1, stall3, bubble3, flush3;
   logic [31:0] nextPc1, nextPc3, stallCnt1, stallCnt3;
   logic        nextPcValid1, nextPcValid3, halted1, halted3;
   logic [63:0] opCnt1, opCnt3;

   int n_checks = 0;
   int n_pass   = 0;

   pipeline_hazard_controller #(.FLUSH_CYCLES(1)) u_dut1 (
      .clk(clk), .rstN(rstN), .stallReq(stallReq), .stageValid(stageValid),
      .flushReq(flushReq), .flushPc(flushPc), .commitCount(commitCount),
      .haltReq(haltReq), .resumeReq(resumeReq), .stall(stall1), .bubble(bubble1),
      .flush(flush1), .nextPc(nextPc1), .nextPcValid(nextPcValid1), .halted(halted1),
      .opCommitCount(opCnt1), .stallCycleCount(stallCnt1)
   );

   pipeline_hazard_controller #(.FLUSH_CYCLES(3)) u_dut3 (
      .clk(clk), .rstN(rstN), .stallReq(stallReq), .stageValid(stageValid),
      .flushReq(flushReq), .flushPc(flushPc), .commitCount(commitCount),
      .haltReq(haltReq), .resumeReq(resumeReq), .stall(stall3), .bubble(bubble3),
      .flush(flush3), .nextPc(nextPc3), .nextPcValid(nextPcValid3), .halted(halted3),
      .opCommitCount(opCnt3), .stallCycleCount(stallCnt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         $display("FAIL %s: got %h want %h", tag, obs, exp_v);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstN = 1'b0; stallReq = 5'd0; stageValid = 5'd0; flushReq = 5'd0;
      flushPc = '0; commitCount = 2'd0; haltReq = 1'b0; resumeReq = 1'b0;
      tick(); tick();
      chk_eq("rst_stall", 64'(stall1), 64'd0);
      chk_eq("rst_bubble", 64'(bubble1), 64'd0);
      chk_eq("rst_flush", 64'(flush1), 64'd0);
      chk_eq("rst_nextpc", 64'(nextPc1), 64'd0);
      chk_eq("rst_valid", 64'(nextPcValid1), 64'd0);
      chk_eq("rst_halted", 64'(halted1), 64'd0);
      chk_eq("rst_opcnt", opCnt1, 64'd0);
      chk_eq("rst_stallcnt", 64'(stallCnt1), 64'd0);

      // Combinational stall/bubble patterns
      rstN = 1'b1;
      stallReq = 5'b00100; #1;
      chk_eq("stall_00100", 64'(stall1), 64'b00111);
      chk_eq("bubble_00100", 64'(bubble1), 64'b01000);
      stallReq = 5'b10001; #1;
      chk_eq("stall_10001", 64'(stall1), 64'b11111);
      chk_eq("bubble_10001", 64'(bubble1), 64'b00000);
      stallReq = 5'b00010; #1;
      chk_eq("stall_00010", 64'(stall1), 64'b00011);
      chk_eq("bubble_00010", 64'(bubble1), 64'b00100);
      tick();
      stallReq = 5'd0;
      tick();
      chk_eq("stallcnt_1", 64'(stallCnt1), 64'd1);

      // Oldest-wins flush with redirect
      flushReq = 5'b01010; flushPc[3] = 32'h8000_0100; flushPc[1] = 32'h1111_1111;
      tick();
      flushReq = 5'd0; stallReq = 5'b00110; #1;
      chk_eq("fl_mask", 64'(flush1), 64'b00111);
      chk_eq("fl_pc", 64'(nextPc1), 64'h8000_0100);
      chk_eq("fl_valid", 64'(nextPcValid1), 64'd1);
      chk_eq("fl_ovr_stall", 64'(stall1), 64'b00000);
      chk_eq("fl_ovr_bubble", 64'(bubble1), 64'b01000);
      tick();
      stallReq = 5'd0;
      chk_eq("fl_end_mask", 64'(flush1), 64'd0);
      chk_eq("fl_end_valid", 64'(nextPcValid1), 64'd0);
      chk_eq("fl_pc_held", 64'(nextPc1), 64'h8000_0100);

      // Drain and halt
      haltReq = 1'b1; stageValid = 5'b11110;
      tick();
      chk_eq("drain_stall", 64'(stall1), 64'b00001);
      chk_eq("drain_bubble", 64'(bubble1), 64'b00010);
      stageValid = 5'b11100; tick();
      stageValid = 5'b11000; tick();
      stageValid = 5'b10000; tick();
      chk_eq("drain_not_halted", 64'(halted1), 64'd0);
      stageValid = 5'b00000; tick();
      chk_eq("halted", 64'(halted1), 64'd1);
      chk_eq("halted_stall", 64'(stall1), 64'b00001);
      flushReq = 5'b00100; tick();
      flushReq = 5'd0;
      chk_eq("halt_ign_flush", 64'(flush1), 64'd0);
      chk_eq("halt_ign_valid", 64'(nextPcValid1), 64'd0);
      chk_eq("halt_stallcnt", 64'(stallCnt1), 64'd5);
      resumeReq = 1'b1; haltReq = 1'b0; tick();
      resumeReq = 1'b0;
      chk_eq("resume", 64'(halted1), 64'd0);
      chk_eq("resume_stall", 64'(stall1), 64'd0);

      // Simultaneous halt and resume
      haltReq = 1'b1; tick(); tick();
      chk_eq("halt2", 64'(halted1), 64'd1);
      resumeReq = 1'b1; tick();
      resumeReq = 1'b0;
      chk_eq("halt_resume_both", 64'(halted1), 64'd0);
      tick();
      chk_eq("halt_reentered", 64'(stall1), 64'b00001);
      haltReq = 1'b0; tick();
      chk_eq("drain_abort", 64'(halted1), 64'd0);
      chk_eq("stallcnt_7", 64'(stallCnt1), 64'd7);

      // Counters: accumulate, wrap, saturate
      commitCount = 2'd2; tick();
      commitCount = 2'd1; tick();
      chk_eq("opcnt_3", opCnt1, 64'd3);
      force u_dut1.r_op_commit_count = 64'hFFFF_FFFF_FFFF_FFFD;
      #1 release u_dut1.r_op_commit_count;
      commitCount = 2'd2; tick();
      chk_eq("opcnt_max", opCnt1, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      commitCount = 2'd0;
      chk_eq("opcnt_wrap", opCnt1, 64'd1);
      force u_dut1.r_stall_cycle_count = 32'hFFFF_FFFE;
      #1 release u_dut1.r_stall_cycle_count;
      stallReq = 5'b00001; tick();
      chk_eq("stallcnt_max", 64'(stallCnt1), 64'hFFFF_FFFF);
      tick();
      stallReq = 5'd0;
      chk_eq("stallcnt_sat", 64'(stallCnt1), 64'hFFFF_FFFF);

      // Multi-cycle flush with preemption by an older stage
      rstN = 1'b0; tick();
      rstN = 1'b1;
      flushReq = 5'b00100; flushPc[2] = 32'h0000_2000; tick();
      flushReq = 5'd0;
      chk_eq("f3_mask1", 64'(flush3), 64'b00011);
      chk_eq("f3_pc1", 64'(nextPc3), 64'h0000_2000);
      chk_eq("f3_valid1", 64'(nextPcValid3), 64'd1);
      tick();
      chk_eq("f3_mask2", 64'(flush3), 64'b00011);
      chk_eq("f3_valid2", 64'(nextPcValid3), 64'd0);
      flushReq = 5'b10000; flushPc[4] = 32'h0000_4000; tick();
      flushReq = 5'b00010;
      chk_eq("f3_pre_mask", 64'(flush3), 64'b01111);
      chk_eq("f3_pre_pc", 64'(nextPc3), 64'h0000_4000);
      chk_eq("f3_pre_valid", 64'(nextPcValid3), 64'd1);
      tick();
      flushReq = 5'd0;
      chk_eq("f3_low_ign_mask", 64'(flush3), 64'b01111);
      chk_eq("f3_low_ign_pc", 64'(nextPc3), 64'h0000_4000);
      chk_eq("f3_low_ign_valid", 64'(nextPcValid3), 64'd0);
      tick();
      chk_eq("f3_hold3", 64'(flush3), 64'b01111);
      tick();
      chk_eq("f3_done", 64'(flush3), 64'd0);

      // Reset during the second flush cycle
      flushReq = 5'b00100; tick();
      flushReq = 5'd0; tick();
      chk_eq("f3r_mask2", 64'(flush3), 64'b00011);
      rstN = 1'b0; tick();
      rstN = 1'b1;
      chk_eq("f3r_flush", 64'(flush3), 64'd0);
      chk_eq("f3r_valid", 64'(nextPcValid3), 64'd0);
      chk_eq("f3r_pc", 64'(nextPc3), 64'd0);
      chk_eq("f3r_halted", 64'(halted3), 64'd0);
      chk_eq("f3r_opcnt", opCnt3, 64'd0);
      chk_eq("f3r_stallcnt", 64'(stallCnt3), 64'd0);
      tick();
      chk_eq("f3r_noflush1", 64'(flush3), 64'd0);
      chk_eq("f3r_novalid", 64'(nextPcValid3), 64'd0);
      tick();
      chk_eq("f3r_noflush2", 64'(flush3), 64'd0);
      stallReq = 5'b00100; #1;
      chk_eq("f3r_stall_pure", 64'(stall3), 64'b00111);
      chk_eq("f3r_bubble_pure", 64'(bubble3), 64'b01000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
